// File: rtl/key_pkg.sv
// Shared types and default 50 MHz timing for the key bank.
// Channel state encoding lives here so every key_chan agrees on it.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_FILT,
        DOWN,
        REL_FILT
    } key_state_e;

    localparam int DEF_DEB_CYCLES    = 1000000;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;

endpackage

// File: rtl/key_bank_if.sv
// Raw key levels in, debounced state and event pulses out.
// master drives the buttons, slave is the key bank.
interface key_bank_if #(
    parameter int N_KEYS = 8
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;
    logic              any_press;

    modport master (
        output key_in,
        input  key_state, key_press, key_release,
        input  key_long, key_repeat, any_press
    );

    modport slave (
        input  key_in,
        output key_state, key_press, key_release,
        output key_long, key_repeat, any_press
    );
endinterface

// File: rtl/key_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM,
// long-press and auto-repeat counters with registered event pulses.
module key_chan
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    logic s1_q, s2_q, p;
    key_state_e state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic lp_q, lp_d;
    logic press_q, press_d, rel_q, rel_d;
    logic long_q, long_d, rpt_q, rpt_d;
    logic adv;

    assign p = (ACTIVE_LOW != 0) ? ~s2_q : s2_q;

    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        lp_d    = lp_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (p) begin
                    state_d = PRESS_FILT;
                    deb_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (deb_q == DEB_MAX) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                    hold_d  = '0;
                    rep_d   = '0;
                    lp_d    = 1'b0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            DOWN: begin
                if (!p) begin
                    state_d = REL_FILT;
                    deb_d   = '0;
                end else begin
                    adv = 1'b1;
                end
            end
            REL_FILT: begin
                // a bounce back to pressed resumes the hold as if never left
                if (p) begin
                    state_d = DOWN;
                    adv     = 1'b1;
                end else if (deb_q == DEB_MAX) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                    hold_d  = '0;
                    rep_d   = '0;
                    lp_d    = 1'b0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (adv) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HW'(1);
            end else if (!lp_q) begin
                lp_d   = 1'b1;
                long_d = 1'b1;
                rep_d  = '0;
            end else if (REPEAT_EN != 0) begin
                if (rep_q == REP_MAX) begin
                    rep_d = '0;
                    rpt_d = 1'b1;
                end else begin
                    rep_d = rep_q + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= REL_LVL;
            s2_q    <= REL_LVL;
            state_q <= IDLE;
            deb_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            lp_q    <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            s1_q    <= key_in;
            s2_q    <= s1_q;
            state_q <= state_d;
            deb_q   <= deb_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            lp_q    <= lp_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign key_state   = (state_q == DOWN) || (state_q == REL_FILT);
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign key_long    = long_q;
    assign key_repeat  = rpt_q;

endmodule

// File: rtl/key_bank.sv
// N-channel push-button front end: one key_chan per key
// plus a registered OR of all press pulses.
module key_bank
    import key_pkg::*;
#(
    parameter int N_KEYS        = 8,
    parameter int ACTIVE_LOW    = 1,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int REPEAT_EN     = 1
) (
    input logic       clk,
    input logic       rst_n,
    key_bank_if.slave bus
);
    logic [N_KEYS-1:0] state_w, press_w, rel_w, long_w, rpt_w;
    logic any_q, any_d;

    if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2 ||
        LONG_CYCLES <= DEB_CYCLES) begin : g_bad_cfg
        $error("key_bank: illegal timing parameters");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_chan #(
            .ACTIVE_LOW   (ACTIVE_LOW),
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (REPEAT_EN)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (bus.key_in[i]),
            .key_state  (state_w[i]),
            .key_press  (press_w[i]),
            .key_release(rel_w[i]),
            .key_long   (long_w[i]),
            .key_repeat (rpt_w[i])
        );
    end

    always_comb begin
        any_d = |press_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= any_d;
        end
    end

    assign bus.key_state   = state_w;
    assign bus.key_press   = press_w;
    assign bus.key_release = rel_w;
    assign bus.key_long    = long_w;
    assign bus.key_repeat  = rpt_w;
    assign bus.any_press   = any_q;

endmodule
